sram_write_buffer: RTL and testbench
====================================

SRAM_WRITE_BUFFER -- requirements
Module: sram_write_buffer

Interface
REQ-001 SHALL have parameter N_SRAM, default 1: number of SRAM banks, 1..4.
REQ-002 SHALL have parameter INVERT_CE_EN, default 0: 1 makes sram_en and latched_byte_en active-low.
REQ-003 SHALL have parameter BANK_LSB, default 16: lowest address bit of the bank index.
REQ-004 SHALL have one clock; reset is synchronous and active-high. Ports: CLK input 1, rising-edge clock; RST input 1, synchronous active-high reset.
REQ-005 SHALL have req_valid input 1: address-phase request.
REQ-006 SHALL have req_write input 1: 1 = write, 0 = read.
REQ-007 SHALL have req_addr input 32: byte address.
REQ-008 SHALL have req_size input 2: 0 = byte, 1 = half, 2 = word.
REQ-009 SHALL have wdata input 32: write data, valid the cycle after a write address phase.
REQ-010 SHALL have ram_addr output 32: word-aligned SRAM address.
REQ-011 SHALL have ram_wdata output 32: SRAM write data.
REQ-012 SHALL have ram_ren and ram_wen outputs, 1 bit each: SRAM strobes.
REQ-013 SHALL have sram_en output N_SRAM: one-hot bank select, polarity per INVERT_CE_EN.
REQ-014 SHALL have ram_byte_en output 4: SRAM byte-lane enables, active-high.
REQ-015 SHALL have latched_flag output 1, latched_addr output 32, latched_data output 32 and latched_byte_en output 4: the pending-write view used by the read-data merge stage.
REQ-016 SHALL have read_addr output 32 and read_size output 2: read attributes for the cycle in which SRAM data returns.
REQ-017 SHALL have err output 1: one-cycle pulse flagging a rejected request.

Function
REQ-018 SHALL derive byte lanes as follows: size 0 gives 4'b0001 << addr[1:0]; size 1 gives 4'b0011 << addr[1:0]; size 2 gives 4'b1111.
REQ-019 SHALL reject a request that is a half access with addr[0]=1, a word access with addr[1:0]≠0, size 3, or a bank index ≥ N_SRAM; it SHALL pulse err in the next cycle and issue no SRAM access or state change.
REQ-020 SHALL implement states EMPTY, ADDR_HELD (write address captured, data pending) and FULL (write data latched).
REQ-021 SHALL issue an accepted read combinationally in its request cycle: ram_ren=1, ram_addr = req_addr & ~3, sram_en = selected bank. In the next cycle, read_addr = req_addr & ~3 and read_size = req_size.
REQ-022 SHALL capture an accepted write's addr, size and lanes, then go to ADDR_HELD.
REQ-023 SHALL, in ADDR_HELD, capture wdata and go to FULL at the next edge, regardless of req_valid in that cycle.
REQ-024 SHALL commit a pending write in FULL during any cycle without an accepted read: ram_wen=1, ram_addr/ram_byte_en/ram_wdata taken from the latch, then go to EMPTY (or to ADDR_HELD if a new write is accepted in the same cycle).
REQ-025 SHALL give reads priority over commits: while in FULL, a read request issues and the latch is held.
REQ-026 SHALL hold latched_flag=1 exactly while in FULL; latched_byte_en SHALL equal the stored lanes XOR {4{INVERT_CE_EN}}.
REQ-027 SHALL accept every request; there is no back-pressure, because any write address phase in FULL forces a commit first.
REQ-028 SHALL never assert ram_ren and ram_wen in the same cycle.
REQ-029 SHALL drive, when idle: strobes 0, sram_en inactive, ram_byte_en 0.

Reset
REQ-030 SHALL, while RST=1 at an edge, go to EMPTY and clear latched_flag, latched_addr, latched_data, latched_byte_en (inactive polarity), read_addr, read_size and err.
REQ-031 SHALL discard a pending write when reset arrives mid-operation, with no SRAM write.

Structure
REQ-032 SHALL place size encodings, the state enum and the lane-mask function in shared package sram_ctrl_pkg.
REQ-033 SHALL implement the alignment/lane/bank logic as sub-module sram_req_check.

Verification
REQ-034 SHALL cover: write word 0x100 = 0xDEADBEEF, then idle → FULL at t+2, ram_wen=1 at t+2 with lanes 1111, EMPTY at t+3.
REQ-035 SHALL cover: byte write 0x103 = 0xAA000000 followed by back-to-back reads of 0x100 → latched_flag=1 with lanes 1000 during the reads, and the commit occurs only after the reads end.
REQ-036 SHALL cover: two consecutive writes 0x10, 0x14 → the first commits during the second's address phase, and both land in SRAM.
REQ-037 SHALL cover: half read at 0x201 and word write at 0x102 → err=1 next cycle, no strobes.
REQ-038 SHALL cover: N_SRAM=2, INVERT_CE_EN=1, read of 0x10000 → sram_en=2'b01 (bank 1 active-low).
REQ-039 SHALL cover: reset asserted in FULL → no ram_wen, and latched_flag=0 the next cycle.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared encodings for the SRAM write buffer: access sizes, buffer state
// and the byte-lane mask helper.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_BAD  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_ADDR_HELD = 2'd1,
        ST_FULL      = 2'd2
    } wb_state_e;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // Byte lanes touched by an access of the given size at byte offset lo.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b0001 << lo;
            SZ_HALF: m = 4'b0011 << lo;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sram_write_buffer_if.sv
// Request / SRAM / pending-write bus of the SRAM write buffer.
interface sram_write_buffer_if #(
    parameter int N_SRAM = 1
) ();
    logic              req_valid;
    logic              req_write;
    logic [31:0]       req_addr;
    logic [1:0]        req_size;
    logic [31:0]       wdata;

    logic [31:0]       ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_ren;
    logic              ram_wen;
    logic [N_SRAM-1:0] sram_en;
    logic [3:0]        ram_byte_en;

    logic              latched_flag;
    logic [31:0]       latched_addr;
    logic [31:0]       latched_data;
    logic [3:0]        latched_byte_en;

    logic [31:0]       read_addr;
    logic [1:0]        read_size;
    logic              err;

    modport master (
        output req_valid, req_write, req_addr, req_size, wdata,
        input  ram_addr, ram_wdata, ram_ren, ram_wen, sram_en, ram_byte_en,
        input  latched_flag, latched_addr, latched_data, latched_byte_en,
        input  read_addr, read_size, err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, wdata,
        output ram_addr, ram_wdata, ram_ren, ram_wen, sram_en, ram_byte_en,
        output latched_flag, latched_addr, latched_data, latched_byte_en,
        output read_addr, read_size, err
    );
endinterface

// File: rtl/sram_req_check.sv
// Request qualification: alignment, byte lanes and bank decode.
module sram_req_check
    import sram_ctrl_pkg::*;
#(
    parameter int N_SRAM   = 1,
    parameter int BANK_LSB = 16
) (
    input  logic              i_valid,
    input  logic [31:0]       i_addr,
    input  logic [1:0]        i_size,
    output logic              o_accept,
    output logic              o_reject,
    output logic [3:0]        o_lanes,
    output logic [N_SRAM-1:0] o_bank_oh
);

    logic [31:0] w_bank;
    logic        w_align_ok;
    logic        w_bank_ok;

    assign w_bank    = i_addr >> BANK_LSB;
    assign w_bank_ok = (w_bank < 32'(N_SRAM));
    assign o_lanes   = lane_mask(i_size, i_addr[1:0]);
    assign o_accept  = i_valid & w_align_ok & w_bank_ok;
    assign o_reject  = i_valid & ~(w_align_ok & w_bank_ok);

    // Natural alignment per access size; size 3 is never legal.
    always_comb begin
        w_align_ok = 1'b0;
        case (i_size)
            SZ_BYTE: w_align_ok = 1'b1;
            SZ_HALF: w_align_ok = ~i_addr[0];
            SZ_WORD: w_align_ok = (i_addr[1:0] == 2'b00);
            default: w_align_ok = 1'b0;
        endcase
    end

    // One-hot bank select from the bank index field.
    always_comb begin
        o_bank_oh = '0;
        for (int i = 0; i < N_SRAM; i++) begin
            o_bank_oh[i] = (w_bank == 32'(i));
        end
    end

endmodule

// File: rtl/sram_write_buffer.sv
// Single-entry SRAM write buffer: writes are latched and committed in a
// later idle cycle, reads go straight to the SRAM and take priority.
module sram_write_buffer
    import sram_ctrl_pkg::*;
#(
    parameter int N_SRAM       = 1,
    parameter int INVERT_CE_EN = 0,
    parameter int BANK_LSB     = 16
) (
    input  logic CLK,
    input  logic RST,
    sram_write_buffer_if.slave bus
);

    localparam logic INV = (INVERT_CE_EN != 0);

    wb_state_e         r_state;
    logic [31:0]       r_lat_addr;
    logic [31:0]       r_lat_data;
    logic [3:0]        r_lat_lanes;
    logic [N_SRAM-1:0] r_lat_bank;
    logic [31:0]       r_read_addr;
    logic [1:0]        r_read_size;
    logic              r_err;

    logic              w_accept;
    logic              w_reject;
    logic [3:0]        w_lanes;
    logic [N_SRAM-1:0] w_bank_oh;
    logic [31:0]       w_req_word;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_commit;
    logic [31:0]       w_ram_addr;
    logic [31:0]       w_ram_wdata;
    logic [3:0]        w_ram_byte_en;
    logic [N_SRAM-1:0] w_en_hi;

    sram_req_check #(
        .N_SRAM   (N_SRAM),
        .BANK_LSB (BANK_LSB)
    ) u_check (
        .i_valid   (bus.req_valid),
        .i_addr    (bus.req_addr),
        .i_size    (bus.req_size),
        .o_accept  (w_accept),
        .o_reject  (w_reject),
        .o_lanes   (w_lanes),
        .o_bank_oh (w_bank_oh)
    );

    assign w_req_word = {bus.req_addr[31:2], 2'b00};
    // Strobes are held off while reset is asserted so a pending write is
    // dropped rather than committed in the reset cycle.
    assign w_rd_acc   = ~RST & w_accept & ~bus.req_write;
    // The cycle after a write address phase is its data phase; a write
    // address presented there is not taken.
    assign w_wr_acc   = ~RST & w_accept & bus.req_write & (r_state != ST_ADDR_HELD);
    assign w_commit   = ~RST & (r_state == ST_FULL) & ~w_rd_acc;

    // Buffer state: capture address, then data, then commit when the SRAM is free.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY:     if (w_wr_acc) r_state <= ST_ADDR_HELD;
                ST_ADDR_HELD: r_state <= ST_FULL;
                ST_FULL:      if (w_commit) r_state <= w_wr_acc ? ST_ADDR_HELD : ST_EMPTY;
                default:      r_state <= ST_EMPTY;
            endcase
        end
    end

    // Pending-write latch: address/lanes/bank at the address phase, data one cycle later.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_lat_addr  <= '0;
            r_lat_data  <= '0;
            r_lat_lanes <= '0;
            r_lat_bank  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_lat_addr  <= w_req_word;
                r_lat_lanes <= w_lanes;
                r_lat_bank  <= w_bank_oh;
            end
            if (r_state == ST_ADDR_HELD) begin
                r_lat_data <= bus.wdata;
            end
        end
    end

    // Read attributes for the data-return cycle, and the reject pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_read_addr <= '0;
            r_read_size <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_reject;
            if (w_rd_acc) begin
                r_read_addr <= w_req_word;
                r_read_size <= bus.req_size;
            end
        end
    end

    // SRAM port mux: an issued read, else the commit from the latch, else idle.
    always_comb begin
        w_ram_addr    = '0;
        w_ram_wdata   = '0;
        w_ram_byte_en = '0;
        w_en_hi       = '0;
        if (w_rd_acc) begin
            w_ram_addr    = w_req_word;
            w_ram_byte_en = w_lanes;
            w_en_hi       = w_bank_oh;
        end else if (w_commit) begin
            w_ram_addr    = r_lat_addr;
            w_ram_wdata   = r_lat_data;
            w_ram_byte_en = r_lat_lanes;
            w_en_hi       = r_lat_bank;
        end
    end

    assign bus.ram_ren         = w_rd_acc;
    assign bus.ram_wen         = w_commit;
    assign bus.ram_addr        = w_ram_addr;
    assign bus.ram_wdata       = w_ram_wdata;
    assign bus.ram_byte_en     = w_ram_byte_en;
    assign bus.sram_en         = w_en_hi ^ {N_SRAM{INV}};

    assign bus.latched_flag    = (r_state == ST_FULL);
    assign bus.latched_addr    = r_lat_addr;
    assign bus.latched_data    = r_lat_data;
    assign bus.latched_byte_en = r_lat_lanes ^ {4{INV}};

    assign bus.read_addr       = r_read_addr;
    assign bus.read_size       = r_read_size;
    assign bus.err             = r_err;

endmodule

// File: tb/tb_sram_write_buffer.sv
// Directed bench for sram_write_buffer: one single-bank instance and one
// two-bank, active-low-enable instance, plus a small SRAM model.
module tb_sram_write_buffer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   wr_cnt = 0;
    logic [31:0] mem [logic [31:0]];

    always #5 clk = ~clk;

    sram_write_buffer_if #(.N_SRAM(1)) bus_a ();
    sram_write_buffer_if #(.N_SRAM(2)) bus_b ();

    sram_write_buffer #(.N_SRAM(1), .INVERT_CE_EN(0), .BANK_LSB(16)) dut_a (
        .CLK (clk),
        .RST (rst),
        .bus (bus_a)
    );

    sram_write_buffer #(.N_SRAM(2), .INVERT_CE_EN(1), .BANK_LSB(16)) dut_b (
        .CLK (clk),
        .RST (rst),
        .bus (bus_b)
    );

    // SRAM model for instance A, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus_a.ram_wen === 1'b1) begin
            logic [31:0] old;
            old = mem.exists(bus_a.ram_addr) ? mem[bus_a.ram_addr] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (bus_a.ram_byte_en[b]) old[b*8 +: 8] = bus_a.ram_wdata[b*8 +: 8];
            mem[bus_a.ram_addr] = old;
            wr_cnt++;
        end
    end

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic drv_a(input logic v, input logic w, input logic [31:0] a,
                         input logic [1:0] s, input logic [31:0] d);
        bus_a.req_valid = v;
        bus_a.req_write = w;
        bus_a.req_addr  = a;
        bus_a.req_size  = s;
        bus_a.wdata     = d;
        #1;
    endtask

    task automatic idle_a();
        drv_a(1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus_b.req_valid = 1'b0;
        bus_b.req_write = 1'b0;
        bus_b.req_addr  = 32'h0;
        bus_b.req_size  = 2'd0;
        bus_b.wdata     = 32'h0;
        idle_a();

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check_vec("rst_flag",   32'(bus_a.latched_flag),    32'h0);
        check_vec("rst_lben",   32'(bus_a.latched_byte_en), 32'h0);
        check_vec("rst_raddr",  bus_a.read_addr,            32'h0);
        check_vec("rst_rsize",  32'(bus_a.read_size),       32'h0);
        check_vec("rst_err",    32'(bus_a.err),             32'h0);
        check_vec("rst_stb",    32'({bus_a.ram_ren, bus_a.ram_wen}), 32'h0);
        check_vec("rst_en_a",   32'(bus_a.sram_en),         32'h0);
        check_vec("rst_lben_b", 32'(bus_b.latched_byte_en), 32'hF);
        check_vec("rst_en_b",   32'(bus_b.sram_en),         32'h3);
        rst = 1'b0;
        nxt();

        // Word write 0x100 = DEADBEEF, then idle
        drv_a(1'b1, 1'b1, 32'h100, 2'd2, 32'h0);
        check_vec("w1_t0_stb", 32'({bus_a.ram_ren, bus_a.ram_wen}), 32'h0);
        nxt();
        drv_a(1'b0, 1'b0, 32'h0, 2'd0, 32'hDEADBEEF);
        check_vec("w1_t1_flag", 32'(bus_a.latched_flag), 32'h0);
        nxt();
        idle_a();
        check_vec("w1_t2_flag",  32'(bus_a.latched_flag),    32'h1);
        check_vec("w1_t2_ladr",  bus_a.latched_addr,         32'h100);
        check_vec("w1_t2_ldat",  bus_a.latched_data,         32'hDEADBEEF);
        check_vec("w1_t2_wen",   32'(bus_a.ram_wen),         32'h1);
        check_vec("w1_t2_ren",   32'(bus_a.ram_ren),         32'h0);
        check_vec("w1_t2_addr",  bus_a.ram_addr,             32'h100);
        check_vec("w1_t2_wdat",  bus_a.ram_wdata,            32'hDEADBEEF);
        check_vec("w1_t2_ben",   32'(bus_a.ram_byte_en),     32'hF);
        check_vec("w1_t2_en",    32'(bus_a.sram_en),         32'h1);
        nxt();
        check_vec("w1_t3_flag",  32'(bus_a.latched_flag),    32'h0);
        check_vec("w1_t3_wen",   32'(bus_a.ram_wen),         32'h0);
        check_vec("w1_t3_ben",   32'(bus_a.ram_byte_en),     32'h0);
        check_vec("w1_mem",      mem_rd(32'h100),            32'hDEADBEEF);

        // Byte write 0x103 = AA000000, then two reads of 0x100 ahead of the commit
        drv_a(1'b1, 1'b1, 32'h103, 2'd0, 32'h0);
        nxt();
        drv_a(1'b0, 1'b0, 32'h0, 2'd0, 32'hAA000000);
        nxt();
        for (int r = 0; r < 2; r++) begin
            drv_a(1'b1, 1'b0, 32'h100, 2'd2, 32'h0);
            check_vec("rd_ren",   32'(bus_a.ram_ren),         32'h1);
            check_vec("rd_wen",   32'(bus_a.ram_wen),         32'h0);
            check_vec("rd_addr",  bus_a.ram_addr,             32'h100);
            check_vec("rd_flag",  32'(bus_a.latched_flag),    32'h1);
            check_vec("rd_lben",  32'(bus_a.latched_byte_en), 32'h8);
            nxt();
        end
        idle_a();
        check_vec("b_raddr", bus_a.read_addr,         32'h100);
        check_vec("b_rsize", 32'(bus_a.read_size),    32'h2);
        check_vec("b_wen",   32'(bus_a.ram_wen),      32'h1);
        check_vec("b_addr",  bus_a.ram_addr,          32'h100);
        check_vec("b_wdat",  bus_a.ram_wdata,         32'hAA000000);
        check_vec("b_ben",   32'(bus_a.ram_byte_en),  32'h8);
        nxt();
        check_vec("b_flag",  32'(bus_a.latched_flag), 32'h0);
        check_vec("b_mem",   mem_rd(32'h100),         32'hAAADBEEF);

        // Two writes 0x10, 0x14: first commits during the second's address phase
        drv_a(1'b1, 1'b1, 32'h10, 2'd2, 32'h0);
        nxt();
        drv_a(1'b0, 1'b0, 32'h0, 2'd0, 32'h11111111);
        nxt();
        drv_a(1'b1, 1'b1, 32'h14, 2'd2, 32'h0);
        check_vec("ww_wen1",  32'(bus_a.ram_wen), 32'h1);
        check_vec("ww_addr1", bus_a.ram_addr,     32'h10);
        check_vec("ww_wdat1", bus_a.ram_wdata,    32'h11111111);
        nxt();
        drv_a(1'b0, 1'b0, 32'h0, 2'd0, 32'h22222222);
        check_vec("ww_hold",  32'(bus_a.ram_wen), 32'h0);
        nxt();
        idle_a();
        check_vec("ww_wen2",  32'(bus_a.ram_wen), 32'h1);
        check_vec("ww_addr2", bus_a.ram_addr,     32'h14);
        nxt();
        check_vec("ww_mem1",  mem_rd(32'h10),     32'h11111111);
        check_vec("ww_mem2",  mem_rd(32'h14),     32'h22222222);

        // Rejected requests: misaligned half read, misaligned word write, bank out of range
        drv_a(1'b1, 1'b0, 32'h201, 2'd1, 32'h0);
        check_vec("rj_stb0", 32'({bus_a.ram_ren, bus_a.ram_wen}), 32'h0);
        check_vec("rj_en0",  32'(bus_a.sram_en), 32'h0);
        nxt();
        drv_a(1'b1, 1'b1, 32'h102, 2'd2, 32'h0);
        check_vec("rj_err0", 32'(bus_a.err), 32'h1);
        check_vec("rj_stb1", 32'({bus_a.ram_ren, bus_a.ram_wen}), 32'h0);
        nxt();
        drv_a(1'b1, 1'b0, 32'h10000, 2'd2, 32'h0);
        check_vec("rj_err1", 32'(bus_a.err), 32'h1);
        check_vec("rj_stb2", 32'({bus_a.ram_ren, bus_a.ram_wen}), 32'h0);
        check_vec("rj_flag", 32'(bus_a.latched_flag), 32'h0);
        nxt();
        idle_a();
        check_vec("rj_err2", 32'(bus_a.err), 32'h1);
        check_vec("rj_stb3", 32'({bus_a.ram_ren, bus_a.ram_wen}), 32'h0);
        nxt();
        check_vec("rj_err3", 32'(bus_a.err), 32'h0);
        check_vec("rj_stb4", 32'({bus_a.ram_ren, bus_a.ram_wen}), 32'h0);

        // Two banks, active-low enables: read of 0x10000 selects bank 1
        bus_b.req_valid = 1'b1;
        bus_b.req_write = 1'b0;
        bus_b.req_addr  = 32'h10000;
        bus_b.req_size  = 2'd2;
        #1;
        check_vec("bk_en",   32'(bus_b.sram_en),  32'h1);
        check_vec("bk_ren",  32'(bus_b.ram_ren),  32'h1);
        check_vec("bk_addr", bus_b.ram_addr,      32'h10000);
        nxt();
        bus_b.req_valid = 1'b0;
        #1;
        check_vec("bk_raddr", bus_b.read_addr,    32'h10000);
        check_vec("bk_idle",  32'(bus_b.sram_en), 32'h3);
        check_vec("bk_err",   32'(bus_b.err),     32'h0);

        // Reset while FULL discards the pending write
        drv_a(1'b1, 1'b1, 32'h20, 2'd2, 32'h0);
        nxt();
        drv_a(1'b0, 1'b0, 32'h0, 2'd0, 32'h55555555);
        nxt();
        idle_a();
        check_vec("rs_full", 32'(bus_a.latched_flag), 32'h1);
        rst = 1'b1;
        #1;
        check_vec("rs_wen0", 32'(bus_a.ram_wen), 32'h0);
        nxt();
        rst = 1'b0;
        #1;
        check_vec("rs_flag", 32'(bus_a.latched_flag), 32'h0);
        check_vec("rs_wen1", 32'(bus_a.ram_wen),      32'h0);
        nxt();
        check_vec("rs_mem",  mem_rd(32'h20),          32'h0);
        check_vec("wr_cnt",  32'(wr_cnt),             32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
